// File: rtl/dadd_arbiter.sv
// Round-robin arbiter time-sharing one single-shot double adder among NUM_REQ requesters.
// Define DADD_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with a quiet-NaN error reply.
module dadd_arbiter #(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 127,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [64*NUM_REQ-1:0] req_a,
  input  logic [64*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_z,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  adder_reset,
  output logic                  adder_valid,
  output logic [63:0]           adder_a,
  output logic [63:0]           adder_b,
  input  logic [63:0]           adder_z,
  input  logic                  adder_done
);

  localparam logic [63:0] QNAN = 64'hFFF8000000000000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            timeout_hit;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dadd_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  // Search starts just after the last winner, so each requester waits at most NUM_REQ-1 ops.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && reset_n && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // IDLE doubles as the adder reset pulse, so every ISSUE follows at least one reset cycle.
  assign adder_reset = (state == IDLE) || !reset_n;
  assign adder_valid = (state == ISSUE);
  assign busy        = (state != IDLE);

`ifdef DADD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT && wait_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a done in that same cycle takes priority.
  assign timeout_hit = (state == WAIT) && !adder_done && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (adder_done || timeout_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      adder_a    <= '0;
      adder_b    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_z     <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            adder_a <= req_a[64*gnt_idx +: 64];
            adder_b <= req_b[64*gnt_idx +: 64];
            rr_ptr  <= gnt_idx;
            resp_id <= gnt_idx;
          end
        end
        WAIT: begin
          if (adder_done) begin
            resp_z     <= adder_z;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end else if (timeout_hit) begin
            resp_z     <= QNAN;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dadd_arbiter.md
Name: dadd_arbiter

Overview:
- Shares one single-shot double-precision adder (`double_adder`) among NUM_REQ requesters.
- Sequences the adder for every operation: pulse its reset, present operands with input_valid, wait for output_done, return the result to the granted requester.
- Sits between the matrix-multiply accumulation lanes and the one adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16). Localparam ID_W = max(1, $clog2(NUM_REQ)).
- TIMEOUT_CYCLES, 127, maximum WAIT cycles before abort. Used only when DADD_ARB_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  64*NUM_REQ  operand A, slice i = [64*i+63:64*i]
- req_b  in  64*NUM_REQ  operand B, same slicing
- req_ready  out  NUM_REQ  one-hot grant pulse; operands are captured this cycle
- resp_valid  out  1  result available
- resp_ready  in  1  result consumer accepts
- resp_id  out  ID_W  index of the requester that owns resp_z
- resp_z  out  64  IEEE-754 double result
- resp_err  out  1  result aborted by timeout (constant 0 without the macro)
- busy  out  1  state != IDLE
- adder_reset  out  1  drives adder reset (active-high)
- adder_valid  out  1  drives adder input_valid
- adder_a  out  64  drives adder input_a
- adder_b  out  64  drives adder input_b
- adder_z  in  64  adder output_z
- adder_done  in  1  adder output_done (sticky until adder reset)

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Decoded outputs, from the state register: adder_reset = (state==IDLE); adder_valid = (state==ISSUE); busy = (state!=IDLE).
- Reset (reset_n low at the clock edge):
  - state=IDLE, rr_ptr=NUM_REQ-1, operand registers 0, resp_valid=0, resp_id=0, resp_z=0, resp_err=0.
  - Outputs in the reset cycle: req_ready=0, adder_reset=1, adder_a/adder_b=0.
  - Reset mid-operation abandons the operation silently; no response is produced.
- IDLE:
  - If any req_valid is set, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap-around.
  - req_ready[g]=1 combinationally this cycle. Latch req_a/req_b slice g into adder_a/adder_b, latch g into resp_id and rr_ptr, then go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE (exactly 1 cycle): adder_valid=1 and the adder unpacks the operands. Go to WAIT.
- WAIT:
  - adder_done is sampled only in this state, so a stale done from the previous op is never seen.
  - On adder_done=1: resp_z<=adder_z, resp_err<=0, resp_valid<=1, go to RESP.
- RESP:
  - Hold resp_valid, resp_z and resp_id stable until resp_ready=1. Then resp_valid<=0 and go to IDLE.
  - IDLE lasts at least 1 cycle, which guarantees the adder reset pulse before the next ISSUE.
- Latency: grant cycle at T. ISSUE at T+1. WAIT from T+2. resp_valid rises the cycle after adder_done is first seen in WAIT.
- Requester rule: a requester must hold req_valid and its operands until it sees req_ready. Dropping req_valid before grant is legal and loses nothing.
- Fairness: a requester waits at most NUM_REQ-1 other operations.
- adder_a/adder_b stay constant from grant until the next grant.
- resp_valid=1 together with resp_ready=1 in the same cycle completes the handshake in that cycle.

Optional Feature:
- Macro: DADD_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears in ISSUE and increments in WAIT.
  - If it reaches TIMEOUT_CYCLES with adder_done still 0: resp_z<=64'hFFF8000000000000 (quiet NaN), resp_err<=1, resp_valid<=1, go to RESP.
  - adder_done and timeout in the same cycle: adder_done wins, err=0.
- Undefined: no counter; resp_err tied 0; WAIT waits indefinitely.

Test Plan:
- Single op: req 0, a=64'h3FF0000000000000, b=64'h4000000000000000 (1.0+2.0) -> resp_z=64'h4008000000000000, resp_id=0, resp_err=0; req_ready[0] one cycle; adder_valid exactly one cycle, one cycle after grant.
- Round-robin: all 4 req_valid held high for 5 ops, each op 1.0+1.0 -> grant order 0,1,2,3,0; every resp_z=64'h4000000000000000, resp_id matches the grant.
- Backpressure: resp_ready low 10 cycles after resp_valid -> resp_z/resp_id stable, resp_valid held, no req_ready; resp_ready high -> IDLE next cycle with adder_reset=1.
- Special cases: +Inf (64'h7FF0000000000000) + -Inf (64'hFFF0000000000000) -> resp_z=64'hFFF8000000000000. Then 2.0 + -2.0 -> 64'h0000000000000000, proving the adder reset between ops.
- Reset mid-op: reset_n low 1 cycle during WAIT -> resp_valid=0, busy=0, adder_reset=1. Next req 1.0+2.0 completes correctly with resp_id of the new requester.
- Timeout (macro defined, TIMEOUT_CYCLES=16, adder model with adder_done tied 0) -> resp_valid after 16 WAIT cycles, resp_z=64'hFFF8000000000000, resp_err=1; next op still granted normally.
